// File: rtl/ahb_pkg.sv
// Shared AHB transfer/burst encodings and burst-length decode used by the bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Zero means the burst has no fixed length and may be re-arbitrated.
    function automatic logic [4:0] burst_len(input hburst_e burst);
        case (burst)
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping,
// so the requester at ptr itself has the lowest priority.
module rr_priority_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [MW-1:0] w_idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = MW'((32'(ptr) + i) % N);
            if (!valid && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant plus address/data-phase owner pipeline.
// Fixed-length bursts and locked sequences close arbitration until they complete.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    localparam int unsigned MW = $clog2(NUM_MASTERS)
) (
    input  logic                   clock,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_data,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DefIdx   = MW'(DEFAULT_MASTER);

    typedef enum logic [1:0] {
        StArb,
        StBurst,
        StLocked
    } state_e;

    state_e                 r_state, w_state_nxt;
    logic [3:0]             r_beats_left, w_beats_nxt;
    logic [NUM_MASTERS-1:0] r_hgrant, w_pick_gnt, w_grant_nxt;
    logic [MW-1:0]          r_rr_ptr, r_hmaster, r_hmaster_data;
    logic [MW-1:0]          w_owner, w_pick_idx, w_new_idx;
    logic                   r_hmastlock, w_pick_valid, w_open;
    htrans_e                w_trans;
    logic [4:0]             w_len;

    assign w_trans = htrans_e'(htrans);
    assign w_len   = burst_len(hburst_e'(hburst));

    rr_priority_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .req   (hbusreq),
        .ptr   (r_rr_ptr),
        .gnt   (w_pick_gnt),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_owner    = DefIdx;
        w_pick_idx = DefIdx;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_hgrant[i]) w_owner = MW'(i);
            if (w_pick_gnt[i]) w_pick_idx = MW'(i);
        end
    end

    // w_open marks an accepted edge at which the grant may move to a new owner.
    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats_left;
        w_open      = 1'b0;
        if (hready) begin
            unique case (r_state)
                StArb: begin
                    if (hlock[w_owner]) begin
                        w_state_nxt = StLocked;
                    end else if (w_trans == NONSEQ && w_len != 5'd0) begin
                        w_beats_nxt = 4'(w_len - 5'd1);
                        w_state_nxt = StBurst;
                    end else begin
                        w_open = 1'b1;
                    end
                end
                StBurst: begin
                    unique case (w_trans)
                        SEQ: begin
                            if (r_beats_left <= 4'd1) begin
                                w_beats_nxt = 4'd0;
                                w_state_nxt = StArb;
                                w_open      = 1'b1;
                            end else begin
                                w_beats_nxt = r_beats_left - 4'd1;
                            end
                        end
                        BUSY: begin
                        end
                        IDLE: begin
                            w_beats_nxt = 4'd0;
                            w_state_nxt = StArb;
                            w_open      = 1'b1;
                        end
                        NONSEQ: begin
                            if (w_len != 5'd0) begin
                                w_beats_nxt = 4'(w_len - 5'd1);
                            end else begin
                                w_beats_nxt = 4'd0;
                                w_state_nxt = StArb;
                                w_open      = 1'b1;
                            end
                        end
                    endcase
                end
                StLocked: begin
                    if (!hlock[w_owner]) begin
                        w_state_nxt = StArb;
                        w_open      = 1'b1;
                    end
                end
                default: w_state_nxt = StArb;
            endcase
        end
        w_grant_nxt = w_pick_valid ? w_pick_gnt : DefGrant;
        w_new_idx   = w_pick_valid ? w_pick_idx : DefIdx;
    end

    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn) begin
            r_state        <= StArb;
            r_beats_left   <= 4'd0;
            r_hgrant       <= DefGrant;
            r_rr_ptr       <= DefIdx;
            r_hmaster      <= DefIdx;
            r_hmaster_data <= DefIdx;
            r_hmastlock    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beats_left <= w_beats_nxt;
            if (hready) begin
                r_hmaster      <= w_owner;
                r_hmaster_data <= r_hmaster;
                r_hmastlock    <= hlock[w_owner];
            end
            if (w_open) begin
                r_hgrant <= w_grant_nxt;
                if (w_grant_nxt != r_hgrant) r_rr_ptr <= w_new_idx;
            end
        end
    end

    assign hgrant       = r_hgrant;
    assign hmaster      = r_hmaster;
    assign hmaster_data = r_hmaster_data;
    assign hmastlock    = r_hmastlock;

endmodule
